// File: rtl/cache_fill_ctrl_pkg.sv
// cache_fill_ctrl_pkg: shared cache geometry, address field positions and fill state enum
package cache_fill_ctrl_pkg;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int NUM_SETS = 64;
  localparam int WORDS    = 8;
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int WORD_W   = $clog2(WORDS);
  localparam int WORD_LSB = 1;
  localparam int SET_LSB  = WORD_LSB + WORD_W;
  localparam int TAG_LSB  = SET_LSB + SET_W;
  localparam int TAG_W    = ADDR_W - TAG_LSB;
  localparam int CNT_W    = WORD_W + 1;
  typedef enum logic {IDLE, FILL} fill_state_e;
endpackage

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: miss request, memory read and data/tag array write signals of the fill controller
//   master: controller side (drives memory requests and array writes)
//   slave : environment side (requester, memory, data/tag arrays)
interface cache_fill_ctrl_if;
  import cache_fill_ctrl_pkg::*;
  logic                miss_detected;
  logic [ADDR_W-1:0]   miss_address;
  logic                miss_way;
  logic                memory_data_valid;
  logic [DATA_W-1:0]   memory_data;
  logic                mem_en;
  logic [ADDR_W-1:0]   mem_address;
  logic                fsm_busy;
  logic [DATA_W-1:0]   data_out;
  logic [NUM_SETS-1:0] block_enable;
  logic [WORDS-1:0]    word_enable;
  logic                write_en0;
  logic                write_en1;
  logic                write_tag_array;
  logic                tag_way;
  modport master (
    input  miss_detected, miss_address, miss_way, memory_data_valid, memory_data,
    output mem_en, mem_address, fsm_busy, data_out, block_enable, word_enable,
           write_en0, write_en1, write_tag_array, tag_way
  );
  modport slave (
    output miss_detected, miss_address, miss_way, memory_data_valid, memory_data,
    input  mem_en, mem_address, fsm_busy, data_out, block_enable, word_enable,
           write_en0, write_en1, write_tag_array, tag_way
  );
endinterface

// File: rtl/cache_fill_ctrl_onehot_decoder.sv
// onehot_decoder: N-bit index to 2^N one-hot vector, all zero when en is low
//   en: enable, idx: binary index, onehot: decoded select
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic            en,
  input  logic [N-1:0]    idx,
  output logic [2**N-1:0] onehot
);
  localparam int M = 2**N;
  assign onehot = en ? ({{(M-1){1'b0}}, 1'b1} << idx) : '0;
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-fill controller streaming 8 memory reads into one way/set of the cache data array
//   clk: clock, rst: asynchronous active-low reset
//   bus: miss request in, memory request/return, data array enables/strobes, tag write pulse
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.master bus
);
  fill_state_e      state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             way_q, way_d;
  logic [CNT_W-1:0] issue_q, issue_d, recv_q, recv_d;
  logic             fill, beat, unused_addr_bits;
  assign unused_addr_bits = ^bus.miss_address[SET_LSB-1:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      set_q   <= '0;
      way_q   <= 1'b0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      way_q   <= way_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    set_d   = set_q;
    way_d   = way_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    fill    = state_q == FILL;
    beat    = fill && bus.memory_data_valid;
    if (!fill && bus.miss_detected) begin
      state_d = FILL;
      tag_d   = bus.miss_address[TAG_LSB +: TAG_W];
      set_d   = bus.miss_address[SET_LSB +: SET_W];
      way_d   = bus.miss_way;
      issue_d = '0;
      recv_d  = '0;
    end
    if (fill) begin
      // issue_q[MSB] marks all 8 requests sent
      issue_d = issue_q + {{(CNT_W-1){1'b0}}, ~issue_q[CNT_W-1]};
      recv_d  = recv_q + {{(CNT_W-1){1'b0}}, beat};
      state_d = (beat && recv_q == CNT_W'(WORDS-1)) ? IDLE : FILL;
    end
    bus.fsm_busy        = fill;
    bus.mem_en          = fill && !issue_q[CNT_W-1];
    bus.mem_address     = bus.mem_en ? {tag_q, set_q, issue_q[WORD_W-1:0], 1'b0} : '0;
    bus.data_out        = bus.memory_data;
    bus.write_en0       = beat && !way_q;
    bus.write_en1       = beat && way_q;
    bus.write_tag_array = beat && recv_q == CNT_W'(WORDS-1);
    bus.tag_way         = fill && way_q;
  end
  onehot_decoder #(.N(SET_W)) u_block_dec (
    .en     (fill),
    .idx    (set_q),
    .onehot (bus.block_enable)
  );
  onehot_decoder #(.N(WORD_W)) u_word_dec (
    .en     (beat),
    .idx    (recv_q[WORD_W-1:0]),
    .onehot (bus.word_enable)
  );
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: randomized fills checked against a per-fill transaction model
module tb_cache_fill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cache_fill_ctrl_if bus();
  cache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(bus.fsm_busy), 0);
    check({tag, "_mem_en"}, 64'(bus.mem_en), 0);
    check({tag, "_block"}, bus.block_enable, 0);
    check({tag, "_word"}, 64'(bus.word_enable), 0);
    check({tag, "_we"}, {62'd0, bus.write_en1, bus.write_en0}, 0);
    check({tag, "_wta"}, 64'(bus.write_tag_array), 0);
  endtask
  task automatic idle_noise();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.miss_detected = 1'b0;
      bus.memory_data_valid = 1'b1;
      bus.memory_data = 16'($urandom);
      #1 check_quiet("idle_valid");
    end
    @(negedge clk);
    bus.memory_data_valid = 1'b0;
    #1 check_quiet("idle_after");
  endtask
  // One fill: request i goes out on cycle i+1 after acceptance for word base+2i;
  // the k-th valid beat must write word k; the 8th beat carries the tag write.
  task automatic fill(input logic [15:0] addr, input logic way, input int lat, input int gap_pct,
                      input bit hold, input int abort_after, input bit seq_data);
    logic [15:0] base, d;
    int set, beats, c, avail;
    bit v;
    base = {addr[15:4], 4'h0};
    set = int'(addr[9:4]);
    beats = 0;
    c = 0;
    @(negedge clk);
    bus.miss_detected = 1'b1;
    bus.miss_address = addr;
    bus.miss_way = way;
    bus.memory_data_valid = 1'b0;
    #1;
    check("accept_busy", 64'(bus.fsm_busy), 0);
    check("accept_mem_en", 64'(bus.mem_en), 0);
    while (beats < 8) begin
      @(negedge clk);
      c++;
      bus.miss_detected = hold;
      bus.miss_address = ~addr;
      bus.miss_way = ~way;
      avail = c - lat;
      if (avail < 0) avail = 0;
      if (avail > 8) avail = 8;
      v = avail > beats && int'($urandom_range(99)) >= gap_pct;
      d = seq_data ? 16'h1000 + 16'(beats) : 16'($urandom);
      bus.memory_data_valid = v;
      bus.memory_data = d;
      #1;
      check("mem_en", 64'(bus.mem_en), 64'(c <= 8));
      if (c <= 8) check("mem_address", 64'(bus.mem_address), 64'(base + 16'(2 * (c - 1))));
      check("busy", 64'(bus.fsm_busy), 1);
      check("block_enable", bus.block_enable, 64'(1) << set);
      check("word_enable", 64'(bus.word_enable), v ? 64'(1) << beats : 0);
      check("write_en0", 64'(bus.write_en0), 64'(v && !way));
      check("write_en1", 64'(bus.write_en1), 64'(v && way));
      check("write_tag", 64'(bus.write_tag_array), 64'(v && beats == 7));
      if (v) begin
        check("data_out", 64'(bus.data_out), 64'(d));
        if (beats == 7) check("tag_way", 64'(bus.tag_way), 64'(way));
        beats++;
      end
      if (abort_after > 0 && beats == abort_after) begin
        @(negedge clk);
        rst = 1'b0;
        bus.memory_data_valid = 1'b1;
        #1 check_quiet("abort");
        @(negedge clk);
        rst = 1'b1;
        bus.memory_data_valid = 1'b0;
        bus.miss_detected = 1'b0;
        break;
      end
      if (c > 200) begin
        check("fill_timeout", 64'(c), 200);
        break;
      end
    end
  endtask
  initial begin
    bus.miss_detected = 1'b0;
    bus.miss_address = '0;
    bus.miss_way = 1'b0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = '0;
    #2 rst = 1'b0;
    #1 check_quiet("reset");
    check("reset_tag_way", 64'(bus.tag_way), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_noise();
    fill(16'hA4C6, 1'b1, 4, 0, 1'b0, 0, 1'b1);
    fill(16'h7B52, 1'b0, 2, 50, 1'b1, 0, 1'b0);
    fill(16'h5A38, 1'b1, 1, 30, 1'b0, 0, 1'b0);
    fill(16'h1234, 1'b0, 1, 0, 1'b0, 3, 1'b0);
    fill(16'h1234, 1'b1, 3, 20, 1'b0, 0, 1'b0);
    fill(16'h03F0, 1'b0, 1, 0, 1'b0, 0, 1'b0);
    fill(16'h0000, 1'b1, 1, 0, 1'b0, 0, 1'b0);
    idle_noise();
    for (int i = 0; i < 20; i++)
      fill(16'($urandom), 1'($urandom_range(1)), int'($urandom_range(1, 6)),
           int'($urandom_range(0, 60)), 1'($urandom_range(1)), 0, 1'b0);
    @(negedge clk);
    bus.miss_detected = 1'b0;
    bus.memory_data_valid = 1'b0;
    #1 check_quiet("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
